seq_arith_unit: RTL

Parametrised, clocked arithmetic engine for the differentiator datapath. Replaces the combinational multiplier, adder/subtractor and comparator with one operator that has registered outputs and a start/busy/done handshake. ADD, SUB and CMP complete in one cycle. MUL is an iterative shift-add over WIDTH cycles, so the area cost is a single adder. The control FSM issues derivative-coefficient operations (coeff * exponent, term accumulation) through this unit.

---
 rtl/arith_pkg.sv | 17 +
 rtl/shift_add_mul_core.sv | 71 +++++++
 rtl/seq_arith_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit.
// Op codes and control FSM state encoding.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/shift_add_mul_core.sv
// Iterative shift-add multiplier datapath.
// One adder; the FSM in the top level sequences load/step.
module shift_add_mul_core
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_nxt;

  // Accumulator after the current step; the final product on the last step.
  always_comb begin
    acc_nxt = acc_q + (mplr_q[0] ? mcand_q : '0);
  end

  assign prod_o = acc_nxt;
  assign last_o = (cnt_q == '0);

  // Next-state for load and step.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, a_i};
      mplr_d  = b_i;
      cnt_d   = CNT_MAX;
    end else if (step_i) begin
      acc_d   = acc_nxt;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Clocked ADD/SUB/CMP/MUL engine with start/busy/done handshake.
// Single-cycle ops complete at accept; MUL iterates WIDTH cycles.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               lt
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               lt_q, lt_d;

  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign sum  = {1'b0, in1} + {1'b0, in2};
  assign diff = {1'b0, in1} - {1'b0, in2};

  shift_add_mul_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (mul_load),
    .step_i (mul_step),
    .a_i    (in1),
    .b_i    (in2),
    .last_o (mul_last),
    .prod_o (mul_prod)
  );

  // Next-state and output-register updates for the control FSM.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    lt_d     = lt_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          unique case (op_e'(op))
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum};
              done_d   = 1'b1;
            end
            OP_SUB: begin
              result_d = {{(WIDTH-1){1'b0}}, diff};
              done_d   = 1'b1;
            end
            OP_CMP: begin
              result_d = '0;
              lt_d     = (in1 < in2);
              done_d   = 1'b1;
            end
            OP_MUL: begin
              mul_load = 1'b1;
              busy_d   = 1'b1;
              state_d  = MUL_RUN;
            end
            default: ;
          endcase
        end
      end
      MUL_RUN: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_prod;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      lt_q     <= lt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign lt     = lt_q;

endmodule
